// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback so a single ALU and one unified memory port are shared.
// Datapath controls are decoded combinationally from the current state, the
// opcode/funct fields and the ALU flags. Reset forces the FETCH view with all
// write enables and the memory request held low.
module multicycle_control_unit #(
  parameter int ALUCTRL_W     = 3,
  parameter bit BRANCH_ALL    = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 LT,
  input  logic                 LTU,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 mem_req,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal,
  output logic [3:0]           state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Extended codes are cast to the configured width; they are only selected
  // when ALUCTRL_W is wide enough to hold them.
  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(4'b0000);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(4'b0001);
  localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(4'b0010);
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(4'b0011);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(4'b0101);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4'b0100);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(4'b0110);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(4'b0111);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(4'b1000);
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(4'b1001);

  state_e                 state_q, state_d;
  state_e                 cur_s;
  logic                   rdy;
  logic [ALUCTRL_W-1:0]   alu_fn;
  logic                   alu_legal;
  logic                   br_taken;
  logic                   br_legal;

  // Without the handshake every memory access completes in one cycle.
  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // While reset is asserted the outputs present the FETCH state.
  assign cur_s = reset_n ? state_q : S_FETCH;

  // ALU operation and legality decoded from funct3/funct7b5.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    alu_fn    = ALU_ADD;
    alu_legal = 1'b1;
    case (funct3)
      3'b000:  alu_fn = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: begin
        if (ALUCTRL_W >= 4) begin
          case (funct3)
            3'b100:  alu_fn = ALU_XOR;
            3'b001:  alu_fn = ALU_SLL;
            3'b101:  alu_fn = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b011:  alu_fn = ALU_SLTU;
            default: alu_legal = 1'b0;
          endcase
        end else begin
          alu_legal = 1'b0;
        end
      end
    endcase
  end

  // Branch condition and legality from funct3 and the subtract flags.
  always_comb begin
    br_taken = 1'b0;
    br_legal = 1'b1;
    case (funct3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = ~Zero;
      3'b100:  br_taken = LT;
      3'b101:  br_taken = ~LT;
      3'b110:  br_taken = LTU;
      3'b111:  br_taken = ~LTU;
      default: br_legal = 1'b0;
    endcase
    if (!BRANCH_ALL && (funct3 != 3'b000)) br_legal = 1'b0;
  end

  // Next-state selection; TRAP is absorbing until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = alu_legal ? S_EXECR : S_TRAP;
          OP_ITYPE:          state_d = alu_legal ? S_EXECI : S_TRAP;
          OP_BRANCH:         state_d = br_legal ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (rdy) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, independent of block ordering.
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Moore control outputs; write enables and mem_req are masked by reset.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    mem_req    = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    case (cur_s)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = rdy;
        PCWrite   = rdy;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_fn;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_fn;
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = br_taken;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (!reset_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      mem_req  = 1'b0;
    end
  end

  // Immediate format follows the opcode every cycle outside reset.
  always_comb begin
    ImmSrc = 2'b00;
    if (reset_n) begin
      case (op)
        OP_STORE:  ImmSrc = 2'b01;
        OP_BRANCH: ImmSrc = 2'b10;
        OP_JAL:    ImmSrc = 2'b11;
        default:   ImmSrc = 2'b00;
      endcase
    end
  end

  assign illegal   = (cur_s == S_TRAP);
  assign state_dbg = cur_s;

endmodule
